hmem_arb: RTL and testbench
===========================

# hmem_arb

Hart memory arbiter: shares the hart's single external memory bus between the I-cache refill port, the D-cache refill/writeback port and the atomic (AMO) unit. It sits between the caches/AMO unit and the bus interface. It generates the per-beat read strobes `b_rd_i`/`b_rd_d` and the AMO acknowledge `amo_ack` consumed by the pipeline control unit. It holds the bus locked for the full duration of an atomic sequence.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, bus data width (bytes per beat = DATA_W/8, power of two)
- `BEATS`, 4, beats per cache-line burst (power of two, ≥2)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_req` in 1: I-cache line refill request (read burst).
- `i_addr` in ADDR_W: I-cache line address.
- `d_req` in 1: D-cache line request.
- `d_we` in 1: 1 = writeback burst, 0 = refill burst.
- `d_addr` in ADDR_W: D-cache line address.
- `d_wdata` in DATA_W: current writeback beat.
- `d_wnext` out 1: writeback beat accepted; D-cache advances `d_wdata`.
- `amo_req` in 1: AMO unit requests and holds the bus.
- `a_we` in 1: current AMO access is a write.
- `a_addr` in ADDR_W: AMO access address.
- `a_wdata` in DATA_W: AMO write data.
- `amo_ack` out 1: AMO single access completed.
- `b_req` out 1: bus access valid.
- `b_we` out 1: bus write.
- `b_addr` out ADDR_W: bus address.
- `b_wdata` out DATA_W: bus write data.
- `b_lock` out 1: bus locked (atomic sequence).
- `b_ack` in 1: bus beat complete.
- `b_rd_i` out 1: read beat for I-cache; data on the bus read bus.
- `b_rd_d` out 1: read beat for D-cache; data on the bus read bus.

## Operation
- FSM states:
  - IDLE: no grant.
  - GNT_I: I-cache burst.
  - GNT_D: D-cache burst.
  - GNT_A: AMO sequence.
- Arbitration in IDLE only, one grant per cycle:
  - `amo_req` has highest priority → GNT_A.
  - Otherwise, with only one cache requesting, that cache is granted.
  - With both caches requesting, round-robin: grant the cache not served last.
  - `rr_last` flag resets to I, so D wins the first tie.
  - `rr_last` updates on entering GNT_I or GNT_D.
- On a cache grant:
  - Capture base = req addr with low log2(BEATS·DATA_W/8) bits forced to 0.
  - Capture `d_we` for a D-cache grant.
  - Clear beat counter `beat` (width log2 BEATS).
- GNT_I / GNT_D:
  - `b_req`=1 continuously.
  - `b_addr` = base + beat·(DATA_W/8).
  - `b_we` = captured we (0 for I).
  - `b_wdata` = `d_wdata`.
- Each `b_ack` in a cache grant:
  - `beat` increments.
  - Read grant: `b_rd_i` or `b_rd_d` = `b_ack` (combinational, same cycle).
  - Write grant: `d_wnext` = `b_ack`.
  - On `b_ack` with `beat`==BEATS-1: `beat` wraps to 0 and FSM → IDLE.
- Cache request deassertion mid-burst is ignored; the burst always completes BEATS beats.
- GNT_A:
  - `b_lock`=1.
  - `b_req`=`amo_req`.
  - `b_addr`/`b_we`/`b_wdata` = `a_addr`/`a_we`/`a_wdata`.
  - `amo_ack` = `b_ack`.
  - AMO unit changes `a_*` only the cycle after `amo_ack`.
  - `amo_req` sampled 0 → IDLE next cycle; `b_lock` drops with the state.
- `b_ack` while `b_req`=0 (IDLE, or GNT_A with `amo_req`=0) is ignored: no strobe, no state change.

## Timing
- Reset (async, immediate):
  - State: IDLE.
  - All outputs 0.
  - `beat`=0.
  - `rr_last`=I.
- Reset asserted mid-burst or mid-AMO: bus released immediately; no strobes emitted.
- Grant latency: request high in IDLE at cycle 0 → `b_req`=1 in cycle 1.
- Burst with `b_ack` every cycle:
  - Beats in cycles 1..BEATS.
  - IDLE in cycle BEATS+1.
  - Earliest next `b_req` in cycle BEATS+2.
- One mandatory IDLE turnaround cycle between any two grants.
- `b_ack` stalls (low cycles) simply extend the current beat; `b_addr` remains stable.
- All bus outputs are decoded from registered state/`beat`/base.
- Strobes (`b_rd_*`, `d_wnext`, `amo_ack`) combinationally follow `b_ack`.
- Simultaneous `amo_req` and cache requests in IDLE: AMO wins; `rr_last` unchanged.

## Test plan
- Reset, then `i_req`=1, `i_addr`=0x1238, BEATS=4, DATA_W=64, `b_ack` every cycle:
  - `b_addr` = 0x1220, 0x1228, 0x1230, 0x1238 in cycles 1–4.
  - `b_rd_i` high 4 cycles; IDLE in cycle 5.
- `i_req` and `d_req` both high from reset:
  - D served first, then I.
  - Repeat with both still high → D, then I again; exactly one IDLE cycle between grants.
- D writeback, `d_addr`=0x4000, `b_ack` pattern 1,0,0,1,1,0,1:
  - `d_wnext` pulses exactly 4 times.
  - `b_addr` holds 0x4008 during the stalls.
  - `b_we`=1 throughout.
- `amo_req` concurrent with `i_req`:
  - AMO granted; read (ack) then write (ack) → `amo_ack` pulses twice.
  - `b_lock`=1 throughout.
  - `amo_req` dropped → I granted 2 cycles later.
- `rst_n` pulled low during beat 2 of a refill:
  - `b_req`/`b_rd_d` fall immediately.
  - After release, a new `d_req` restarts at beat 0 with base address.
- `d_req` dropped after the first beat: burst still completes 4 beats; `b_ack` in IDLE produces no strobe.

Source files
------------

// File: rtl/hmem_arb.sv
// Hart memory arbiter: shares one external bus between I-cache refills,
// D-cache refill/writeback bursts and locked AMO sequences.
module hmem_arb #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int BEATS  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_wnext,
   input  logic              amo_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              amo_ack,
   output logic              b_req,
   output logic              b_we,
   output logic [ADDR_W-1:0] b_addr,
   output logic [DATA_W-1:0] b_wdata,
   output logic              b_lock,
   input  logic              b_ack,
   output logic              b_rd_i,
   output logic              b_rd_d
);

   localparam int BEAT_W  = $clog2(BEATS);
   localparam int STEP_SH = $clog2(DATA_W / 8);
   localparam int OFF_W   = $clog2(BEATS * DATA_W / 8);
   localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_I = 2'd1;
   localparam logic [1:0] GNT_D = 2'd2;
   localparam logic [1:0] GNT_A = 2'd3;

   localparam logic RR_I = 1'b0;
   localparam logic RR_D = 1'b1;

   logic [1:0]        state;
   logic              rr_last;
   logic [BEAT_W-1:0] beat;
   logic              we_q;
   logic [ADDR_W-1:0] base;
   logic              pick_d;
   logic              pick_i;
   logic              last_beat;
   logic              in_cache;
   logic              in_amo;

   // On a tie, D wins unless D was the cache served last.
   assign pick_d    = d_req & (~i_req | (rr_last == RR_I));
   assign pick_i    = i_req & ~pick_d;
   assign last_beat = (beat == BEAT_W'(BEATS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_last <= RR_I;
         beat    <= '0;
         we_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (amo_req) begin
                  state <= GNT_A;
               end else if (pick_d) begin
                  state   <= GNT_D;
                  rr_last <= RR_D;
                  beat    <= '0;
                  we_q    <= d_we;
               end else if (pick_i) begin
                  state   <= GNT_I;
                  rr_last <= RR_I;
                  beat    <= '0;
                  we_q    <= 1'b0;
               end
            end
            GNT_I, GNT_D: begin
               if (b_ack) begin
                  if (last_beat) begin
                     beat  <= '0;
                     state <= IDLE;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            GNT_A: begin
               if (!amo_req) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line base is datapath only; every use is qualified by the granted state.
   always_ff @(posedge clk) begin
      if (state == IDLE && !amo_req) begin
         if (pick_d)      base <= d_addr & LINE_MASK;
         else if (pick_i) base <= i_addr & LINE_MASK;
      end
   end

   assign in_cache = (state == GNT_I) || (state == GNT_D);
   assign in_amo   = (state == GNT_A);

   always_comb begin
      b_req   = in_cache | (in_amo & amo_req);
      b_lock  = in_amo;
      b_we    = 1'b0;
      b_addr  = '0;
      b_wdata = '0;
      if (in_cache) begin
         b_we    = we_q;
         b_addr  = base + (ADDR_W'(beat) << STEP_SH);
         b_wdata = d_wdata;
      end else if (in_amo) begin
         b_we    = a_we;
         b_addr  = a_addr;
         b_wdata = a_wdata;
      end
   end

   // Strobes follow b_ack directly; an ack with b_req low is ignored.
   assign b_rd_i  = (state == GNT_I) & b_ack;
   assign b_rd_d  = (state == GNT_D) & ~we_q & b_ack;
   assign d_wnext = (state == GNT_D) & we_q & b_ack;
   assign amo_ack = in_amo & amo_req & b_ack;

endmodule

// File: tb/tb_hmem_arb.sv
// Bench for hmem_arb: directed scenarios plus random traffic, all checked
// against a transaction-level model of bus ownership.
module tb_hmem_arb;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int BEATS  = 4;
   localparam int LINE_BYTES = BEATS * DATA_W / 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_req, d_req, d_we, amo_req, a_we, b_ack;
   logic [ADDR_W-1:0] i_addr, d_addr, a_addr;
   logic [DATA_W-1:0] d_wdata, a_wdata;
   logic              d_wnext, amo_ack, b_req, b_we, b_lock, b_rd_i, b_rd_d;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;

   hmem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
      .amo_req(amo_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .amo_ack(amo_ack),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
      .b_ack(b_ack), .b_rd_i(b_rd_i), .b_rd_d(b_rd_d)
   );

   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;

   // Model: who owns the bus (0 none, 1 I-cache, 2 D-cache, 3 AMO),
   // how many beats of the line are done, and which cache was served last.
   int              owner;
   int              beats_done;
   int              last_cache;
   logic [ADDR_W-1:0] mbase;
   logic            mwe;

   logic              o_req, o_we, o_lock, o_rdi, o_rdd, o_wnext, o_ack;
   logic [ADDR_W-1:0] o_addr;
   int cnt_rdi, cnt_rdd, cnt_wnext, cnt_ack;

   logic              rec_req [20];
   logic              rec_rdi [20];
   logic              rec_rdd [20];
   logic [ADDR_W-1:0] rec_addr [8];
   bit                pat [7];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      owner = 0;
      beats_done = 0;
      last_cache = 1;
      mbase = '0;
      mwe = 1'b0;
   endtask

   task automatic check_outputs();
      bit                cache;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wdata;
      logic              e_we;
      cache   = (owner == 1) || (owner == 2);
      e_addr  = '0;
      e_wdata = '0;
      e_we    = 1'b0;
      if (cache) begin
         e_addr  = mbase + 64'(beats_done) * (DATA_W / 8);
         e_wdata = d_wdata;
         e_we    = mwe;
      end else if (owner == 3) begin
         e_addr  = a_addr;
         e_wdata = a_wdata;
         e_we    = a_we;
      end
      chk("b_req",   b_req,   cache || (owner == 3 && amo_req));
      chk("b_we",    b_we,    e_we);
      chk("b_addr",  b_addr,  e_addr);
      chk("b_wdata", b_wdata, e_wdata);
      chk("b_lock",  b_lock,  owner == 3);
      chk("b_rd_i",  b_rd_i,  owner == 1 && b_ack);
      chk("b_rd_d",  b_rd_d,  owner == 2 && !mwe && b_ack);
      chk("d_wnext", d_wnext, owner == 2 && mwe && b_ack);
      chk("amo_ack", amo_ack, owner == 3 && amo_req && b_ack);
      o_req = b_req; o_we = b_we; o_lock = b_lock; o_addr = b_addr;
      o_rdi = b_rd_i; o_rdd = b_rd_d; o_wnext = d_wnext; o_ack = amo_ack;
      cnt_rdi += int'(b_rd_i);
      cnt_rdd += int'(b_rd_d);
      cnt_wnext += int'(d_wnext);
      cnt_ack += int'(amo_ack);
   endtask

   task automatic model_update();
      int g;
      case (owner)
         0: begin
            if (amo_req) begin
               owner = 3;
            end else if (i_req || d_req) begin
               if (i_req && d_req) g = (last_cache == 1) ? 2 : 1;
               else                g = d_req ? 2 : 1;
               owner = g;
               last_cache = g;
               beats_done = 0;
               mbase = ((g == 2) ? d_addr : i_addr) & ~64'(LINE_BYTES - 1);
               mwe = (g == 2) && d_we;
            end
         end
         1, 2: begin
            if (b_ack) begin
               beats_done++;
               if (beats_done == BEATS) owner = 0;
            end
         end
         default: if (!amo_req) owner = 0;
      endcase
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      if (rst_n) model_update();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic clear_counts();
      cnt_rdi = 0; cnt_rdd = 0; cnt_wnext = 0; cnt_ack = 0;
   endtask

   initial begin
      bit last_ack;
      rst_n = 1'b0;
      i_req = 0; d_req = 0; d_we = 0; amo_req = 0; a_we = 0; b_ack = 0;
      i_addr = '0; d_addr = '0; a_addr = '0; d_wdata = '0; a_wdata = '0;
      clear_counts();
      model_reset();
      #2;
      check_outputs();
      chk("rst_req", o_req, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // I-cache refill from an unaligned address, ack every cycle
      i_req = 1; i_addr = 64'h1238; b_ack = 1;
      tick();
      i_req = 0;
      clear_counts();
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("t1_addr%0d", k), o_addr, 64'h1220 + 64'(8 * (k - 1)));
      end
      tick();
      chk("t1_idle", o_req, 1'b0);
      chk("t1_rdi_cnt", cnt_rdi, 4);

      // both caches request from reset: D, I, D, I with one idle cycle between
      b_ack = 0;
      do_reset();
      i_req = 1; d_req = 1; i_addr = 64'h3000; d_addr = 64'h5000; d_we = 0; b_ack = 1;
      for (int c = 0; c < 20; c++) begin
         tick();
         rec_req[c] = o_req; rec_rdi[c] = o_rdi; rec_rdd[c] = o_rdd;
      end
      i_req = 0; d_req = 0;
      chk("t2_c0_idle", rec_req[0], 1'b0);
      chk("t2_c1_d", rec_rdd[1], 1'b1);
      chk("t2_c4_d", rec_rdd[4], 1'b1);
      chk("t2_c5_idle", rec_req[5], 1'b0);
      chk("t2_c6_i", rec_rdi[6], 1'b1);
      chk("t2_c10_idle", rec_req[10], 1'b0);
      chk("t2_c11_d", rec_rdd[11], 1'b1);
      chk("t2_c15_idle", rec_req[15], 1'b0);
      chk("t2_c16_i", rec_rdi[16], 1'b1);

      // D writeback with ack stalls
      d_req = 1; d_we = 1; d_addr = 64'h4000; b_ack = 0;
      tick();
      d_req = 0;
      pat = '{1, 0, 0, 1, 1, 0, 1};
      clear_counts();
      for (int k = 0; k < 7; k++) begin
         b_ack = pat[k];
         d_wdata = {$urandom, $urandom};
         tick();
         rec_addr[k] = o_addr;
         chk($sformatf("t3_we%0d", k), o_we, 1'b1);
      end
      chk("t3_stall1", rec_addr[1], 64'h4008);
      chk("t3_stall2", rec_addr[2], 64'h4008);
      chk("t3_beat1", rec_addr[3], 64'h4008);
      chk("t3_wnext_cnt", cnt_wnext, 4);
      b_ack = 1;
      tick();
      chk("t3_idle_wnext", o_wnext, 1'b0);

      // AMO beats a pending I-cache request and holds the lock
      amo_req = 1; i_req = 1; i_addr = 64'h6000; a_addr = 64'h7010; a_we = 0; b_ack = 0;
      tick();
      clear_counts();
      b_ack = 1;
      tick();
      chk("t4_lock1", o_lock, 1'b1);
      a_we = 1; a_wdata = 64'hDEAD_BEEF_0123_4567;
      tick();
      chk("t4_lock2", o_lock, 1'b1);
      amo_req = 0; b_ack = 0;
      tick();
      chk("t4_lock3", o_lock, 1'b1);
      chk("t4_req3", o_req, 1'b0);
      tick();
      chk("t4_req4", o_req, 1'b0);
      b_ack = 1;
      tick();
      chk("t4_i_gnt", o_rdi, 1'b1);
      chk("t4_ack_cnt", cnt_ack, 2);
      i_req = 0;
      repeat (4) tick();

      // reset during beat 2 of a D refill, then restart
      d_req = 1; d_we = 0; d_addr = 64'h8040; b_ack = 1;
      repeat (3) tick();
      do_reset();
      chk("t5_req", o_req, 1'b0);
      chk("t5_rdd", o_rdd, 1'b0);
      tick();
      tick();
      chk("t5_restart_addr", o_addr, 64'h8040);
      chk("t5_restart_rdd", o_rdd, 1'b1);
      d_req = 0;
      repeat (4) tick();

      // D request dropped after the first beat; ack in IDLE is ignored
      d_req = 1; d_we = 0; d_addr = 64'h2010; b_ack = 1;
      tick();
      d_req = 0;
      clear_counts();
      repeat (4) tick();
      tick();
      chk("t6_idle_rdd", o_rdd, 1'b0);
      chk("t6_rdd_cnt", cnt_rdd, 4);

      // random traffic
      last_ack = 0;
      for (int n = 0; n < 800; n++) begin
         i_req  = ($urandom_range(0, 3) == 0);
         d_req  = ($urandom_range(0, 3) == 0);
         d_we   = $urandom_range(0, 1);
         i_addr = {$urandom, $urandom};
         d_addr = {$urandom, $urandom};
         d_wdata = {$urandom, $urandom};
         b_ack  = ($urandom_range(0, 2) != 0);
         if (amo_req) amo_req = ($urandom_range(0, 7) != 0);
         else         amo_req = ($urandom_range(0, 15) == 0);
         if (last_ack || !amo_req) begin
            a_we = $urandom_range(0, 1);
            a_addr = {$urandom, $urandom};
            a_wdata = {$urandom, $urandom};
         end
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            tick();
         end
         last_ack = o_ack;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
